// File: rtl/cdc_xfer_arbiter.sv
// ----------------------------------------------------------------------------
// cdc_xfer_arbiter
//
// Round-robin arbiter that lets NREQ source-domain requesters share one
// handshake data synchroniser. A winner's payload is presented on sync_din
// with sync_dready held high for HOLD_CYC cycles. The arbiter then idles for
// GAP_CYC cycles so the synchroniser can see dready fall before the next
// transfer starts.
//
// Ports
//   clk          source-domain clock, rising edge
//   rstn         synchronous active-low reset
//   req          per-requester level request
//   req_data     payloads, requester i at [i*DWIDTH +: DWIDTH]
//   ack          one-cycle completion pulse for the served requester
//   sync_din     payload to synchroniser (registered)
//   sync_dready  data-ready strobe to synchroniser (registered)
//   busy         high while a transfer or its trailing gap is in progress
//   cur_id       index of the requester being or last served
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req; grants at the edge a req is seen
// HOLD  | sync_dready high, sync_din frozen, HOLD_CYC cycles
// GAP   | sync_dready low, ack pulsed in first cycle, GAP_CYC cycles
// ----------------------------------------------------------------------------
module cdc_xfer_arbiter #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 8,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 3,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic [DWIDTH-1:0]        sync_din,
    output logic                     sync_dready,
    output logic                     busy,
    output logic [IW-1:0]            cur_id
);

    localparam int CMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       last_grant;

    logic                grant_valid;
    logic [IW-1:0]       grant_idx;
    logic [DWIDTH-1:0]   grant_data;

    // Round-robin pick: the lowest set req strictly above last_grant wins;
    // if none, wrap around and take the lowest set req overall.
    logic                found_hi;
    logic                found_lo;
    logic [IW-1:0]       pick_hi;
    logic [IW-1:0]       pick_lo;
    logic [DWIDTH-1:0]   data_hi;
    logic [DWIDTH-1:0]   data_lo;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        data_hi  = '0;
        data_lo  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (req[j] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = IW'(j);
                data_lo  = req_data[j*DWIDTH +: DWIDTH];
            end
            if (req[j] && (IW'(j) > last_grant) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = IW'(j);
                data_hi  = req_data[j*DWIDTH +: DWIDTH];
            end
        end
        grant_valid = found_lo;
        grant_idx   = found_hi ? pick_hi : pick_lo;
        grant_data  = found_hi ? data_hi : data_lo;
    end

    // The counter is loaded with (length-1) on entry to HOLD/GAP and the
    // phase ends on the edge where it reads zero, so each phase lasts exactly
    // its configured number of cycles. It never decrements below zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_grant  <= IW'(NREQ - 1);
            ack         <= '0;
            sync_din    <= '0;
            sync_dready <= 1'b0;
            busy        <= 1'b0;
            cur_id      <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state       <= ST_HOLD;
                        sync_dready <= 1'b1;
                        sync_din    <= grant_data;
                        cur_id      <= grant_idx;
                        last_grant  <= grant_idx;
                        cnt         <= CW'(HOLD_CYC - 1);
                        busy        <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state       <= ST_GAP;
                        sync_dready <= 1'b0;
                        for (int j = 0; j < NREQ; j++) begin
                            ack[j] <= (cur_id == IW'(j));
                        end
                        cnt         <= CW'(GAP_CYC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    sync_dready <= 1'b0;
                    busy        <= 1'b0;
                    cnt         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdc_xfer_arbiter
//
// Drives cdc_xfer_arbiter with directed scenarios followed by random traffic
// and compares every output, every cycle, against a timeline model: each
// transfer is described only by how many cycles have elapsed since its grant.
// ----------------------------------------------------------------------------
module tb_cdc_xfer_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int H    = 4;
    localparam int G    = 3;
    localparam int IDLE_K = H + G + 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     sync_din;
    logic              sync_dready;
    logic              busy;
    logic [1:0]        cur_id;

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_k = cycles elapsed since the last grant edge (IDLE_K or more
    // means the arbiter is idle and may grant at the coming edge).
    int          m_k;
    int          m_last;
    int          m_id;
    logic [DW-1:0] m_din;

    cdc_xfer_arbiter #(
        .NREQ(NREQ), .DWIDTH(DW), .HOLD_CYC(H), .GAP_CYC(G)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .ack(ack),
        .sync_din(sync_din), .sync_dready(sync_dready), .busy(busy),
        .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                              input logic rs);
        bit found;
        int ix;
        if (!rs) begin
            m_k    = IDLE_K;
            m_last = NREQ - 1;
            m_id   = 0;
            m_din  = '0;
        end else if (m_k >= IDLE_K) begin
            found = 0;
            for (int i = 1; i <= NREQ; i++) begin
                ix = (m_last + i) % NREQ;
                if (!found && r[ix]) begin
                    found  = 1;
                    m_id   = ix;
                    m_last = ix;
                    m_din  = d[ix*DW +: DW];
                    m_k    = 1;
                end
            end
        end else begin
            m_k++;
        end
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                        input logic rs);
        logic [NREQ-1:0] e_ack;
        req      = r;
        req_data = d;
        rstn     = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        e_ack = (m_k == H + 1) ? NREQ'(1 << m_id) : '0;
        chk("sync_dready", 32'(sync_dready), 32'(m_k >= 1 && m_k <= H));
        chk("ack",         32'(ack),         32'(e_ack));
        chk("busy",        32'(busy),        32'(m_k <= H + G));
        chk("sync_din",    32'(sync_din),    32'(m_din));
        chk("cur_id",      32'(cur_id),      32'(m_id));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    initial begin
        logic [NREQ*DW-1:0] rd;
        logic [NREQ-1:0]    rr;
        m_k = IDLE_K; m_last = NREQ - 1; m_id = 0; m_din = '0;
        req = '0; req_data = '0; rstn = 1'b0;

        // Reset, then quiet for 20 cycles: outputs hold reset values.
        do_reset(3);
        for (int i = 0; i < 20; i++) step('0, 32'($urandom), 1'b1);
        chk("quiet_din",  32'(sync_din), 32'h0);
        chk("quiet_busy", 32'(busy),     32'h0);

        // Single transfer from requester 1 (payload A5); req dropped and data
        // scrambled during HOLD must not disturb the transfer.
        step(4'b0010, 32'h0000_A500, 1'b1);
        chk("a5_din", 32'(sync_din), 32'hA5);
        chk("a5_id",  32'(cur_id),   32'h1);
        step(4'b0010, 32'h0000_A500, 1'b1);
        for (int i = 0; i < 10; i++) step('0, 32'hFFFF_5AFF, 1'b1);
        chk("a5_din_kept", 32'(sync_din), 32'hA5);

        // All four requesting from reset: order 0,1,2,3,0 at 8-cycle spacing.
        do_reset(2);
        for (int i = 0; i < 4 * (H + G + 1) + 2; i++) step(4'b1111, 32'h4433_2211, 1'b1);

        // After a grant to 3, requesters 0 and 3 alternate (wrap to 0 first).
        do_reset(2);
        step(4'b1000, 32'h9900_0077, 1'b1);
        chk("wrap_first", 32'(cur_id), 32'h3);
        for (int i = 0; i < 2 * (H + G + 1) + 1; i++) step(4'b1001, 32'h9900_0077, 1'b1);

        // Reset at the third cycle of a transfer aborts it without ack and
        // restores requester 0 priority.
        do_reset(2);
        step(4'b0100, 32'h00C3_0000, 1'b1);
        step(4'b0000, 32'h00C3_0000, 1'b1);
        step(4'b0000, 32'h00C3_0000, 1'b0);
        chk("abort_dready", 32'(sync_dready), 32'h0);
        chk("abort_ack",    32'(ack),         32'h0);
        step(4'b1111, 32'h4433_2211, 1'b1);
        chk("abort_regrant", 32'(cur_id), 32'h0);
        for (int i = 0; i < 12; i++) step(4'b1111, 32'h4433_2211, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom};
            rr = 4'($urandom);
            if ($urandom_range(0, 2) == 0) rr = '0;
            step(rr, rd, ($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one data synchroniser channel (2..8).
REQ-002 Parameter DWIDTH, default 8, payload width; equals the synchroniser DWIDTH.
REQ-003 Parameter HOLD_CYC, default 4, cycles sync_dready/sync_din held stable per transfer (>= synchroniser STAGES+2).
REQ-004 Parameter GAP_CYC, default 3, idle cycles after sync_dready falls before next transfer (>= synchroniser STAGES+1).
REQ-005 clk  input  1  source-domain clock; all logic rising-edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 req  input  NREQ  per-requester transfer request, level.
REQ-008 req_data  input  NREQ*DWIDTH  payloads; requester i at bits [i*DWIDTH +: DWIDTH].
REQ-009 ack  output  NREQ  one-cycle completion pulse, one-hot or zero.
REQ-010 sync_din  output  DWIDTH  payload to synchroniser din, registered.
REQ-011 sync_dready  output  1  to synchroniser dready_i, registered.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 cur_id  output  max(1,$clog2(NREQ))  index of requester being or last served.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, GAP; encoding free.
REQ-015 IDLE: if any req bit high at edge N, grant SHALL go to the first set bit scanning from (last_grant+1) mod NREQ upward with wrap; at edge N capture req_data of winner into sync_din, set cur_id, update last_grant, enter HOLD.
REQ-016 IDLE with req all zero: remain IDLE, sync_dready 0, sync_din and cur_id unchanged.
REQ-017 HOLD: sync_dready SHALL be 1 for exactly HOLD_CYC consecutive cycles (N+1..N+HOLD_CYC); sync_din constant throughout.
REQ-018 HOLD->GAP: sync_dready 0 and ack[cur_id]=1 in cycle N+HOLD_CYC+1 only.
REQ-019 GAP SHALL last exactly GAP_CYC cycles; state IDLE in cycle N+HOLD_CYC+GAP_CYC+1, earliest next grant at the edge ending that cycle.
REQ-020 Hold/gap counting SHALL use one down-counter sized for max(HOLD_CYC,GAP_CYC); no wrap past zero.
REQ-021 req and req_data SHALL be ignored in HOLD and GAP; withdrawal of the granted req mid-transfer SHALL NOT abort or shorten the transfer, ack still issued.
REQ-022 Requester still asserting req after its ack SHALL be treated as a new request, served only under round-robin order (no back-to-back starvation of others).
REQ-023 Single requester continuously requesting SHALL be served every HOLD_CYC+GAP_CYC+1 cycles.
REQ-024 At most one ack bit high in any cycle; sync_dready never high in IDLE or GAP.

Reset
REQ-025 rstn=0 at an edge: state IDLE, sync_dready 0, sync_din 0, ack 0, busy 0, cur_id 0, counter 0, last_grant NREQ-1 (so requester 0 has top priority).
REQ-026 Reset mid-HOLD or mid-GAP SHALL abort the transfer with no ack; sync_dready low in the cycle after the reset edge.

Verification
REQ-027 Defaults; req=4'b0010, data1=0xA5 at edge N -> sync_din=0xA5, cur_id=1, sync_dready high N+1..N+4, ack=4'b0010 in N+5 only, busy low from N+8.
REQ-028 req=4'b1111 held, distinct data -> grant order 0,1,2,3,0 with 8-cycle spacing; each ack matches its cur_id.
REQ-029 After grant to 3, req=4'b1001 -> next grant 0 (wrap), then 3.
REQ-030 req1 dropped at N+2 of its transfer, req_data changed in HOLD -> sync_din unchanged, ack[1] still in N+5.
REQ-031 rstn low at N+2 of a transfer -> sync_dready 0 at N+3, no ack, next grant from requester 0 priority.
REQ-032 req=0 for 20 cycles after reset -> all outputs remain at reset values, busy 0.
